// File: rtl/sub_array_collector.sv
// sub_array_collector: round-robin collector of N_SRC valid/ready sources into one registered output word
module sub_array_collector #(
  parameter int N_SRC  = 5,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          in_valid,
  input  logic [N_SRC*DATA_W-1:0]   in_data,
  output logic [N_SRC-1:0]          in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [2:0]                out_src,
  input  logic                      out_ready,
  output logic [15:0]               xfer_count
);
  localparam int PW = $clog2(N_SRC);
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     g;
  logic [PW-1:0]     idx;
  logic              found;
  logic              load_en;
  logic              in_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] src [N_SRC];
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src[i] = in_data[i*DATA_W +: DATA_W];
  end
  assign load_en  = !rst && (!out_valid || out_ready);
  assign out_xfer = out_valid && out_ready;
  assign in_xfer  = |in_ready;
  // first requester at or after ptr, wrapping
  always_comb begin
    g     = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = PW'((int'(ptr) + k) % N_SRC);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    in_ready = (load_en && found) ? N_SRC'(1) << g : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      ptr        <= '0;
      xfer_count <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= src[g];
        out_src   <= 3'(g);
        ptr       <= (g == PW'(N_SRC - 1)) ? '0 : g + 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer && xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_sub_array_collector.sv
// tb_sub_array_collector: randomized + directed scoreboard bench for sub_array_collector
module tb_sub_array_collector;
  localparam int N = 5;
  localparam int W = 8;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     in_valid = '0;
  logic [N*W-1:0]   in_data = '0;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [2:0]       out_src;
  logic             out_ready = 1'b0;
  logic [15:0]      xfer_count;
  int compared = 0;
  int mismatched = 0;
  logic [10:0] q [$];
  logic [10:0] m_last = '0;
  int          m_ptr = 0;
  int          m_count = 0;
  sub_array_collector #(.N_SRC(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .xfer_count(xfer_count)
  );
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [63:0] act, logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h at %0t", n, act, req, $time);
    end
  endfunction
  // scoreboard: expected words are produced by the arbitration rule applied to the model pointer
  always @(negedge clk) begin
    int gsel;
    logic [N-1:0] exp_rdy;
    logic [10:0] w;
    bit ld;
    ld = !rst && (q.size() == 0 || out_ready);
    gsel = -1;
    exp_rdy = '0;
    if (ld)
      for (int k = 0; k < N; k++)
        if (gsel < 0 && in_valid[(m_ptr + k) % N]) gsel = (m_ptr + k) % N;
    if (gsel >= 0) exp_rdy[gsel] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("held_word", 64'({out_src, out_data}), 64'(q.size() != 0 ? q[0] : m_last));
    chk("xfer_count", 64'(xfer_count), 64'(m_count));
    if (rst) begin
      q.delete();
      m_last = '0;
      m_ptr = 0;
      m_count = 0;
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        w = q.pop_front();
        m_last = w;
        if (m_count != 65535) m_count++;
      end
      if (gsel >= 0) begin
        q.push_back({3'(gsel), in_data[gsel*W +: W]});
        m_ptr = (gsel + 1) % N;
      end
    end
  end
  task automatic cyc(input logic r, input logic [N-1:0] v, input logic o, input logic [N*W-1:0] d);
    rst = r;
    in_valid = v;
    out_ready = o;
    in_data = d;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [N*W-1:0] rnd();
    return {$urandom(), 8'($urandom())};
  endfunction
  initial begin
    cyc(1, '0, 0, '0);
    cyc(1, '0, 0, '0);
    cyc(0, 5'b00100, 1, {16'h0, 8'hA5, 16'h0});
    chk("first_data", 64'(out_data), 64'hA5);
    chk("first_src", 64'(out_src), 64'd2);
    cyc(1, '0, 1, '0);
    for (int i = 0; i < 10; i++) cyc(0, 5'b11111, 1, rnd());
    cyc(0, '0, 1, '0);
    chk("ten_words", 64'(xfer_count), 64'd10);
    cyc(0, 5'b00100, 1, rnd());
    for (int i = 0; i < 4; i++) cyc(0, 5'b01010, 0, rnd());
    cyc(0, 5'b01010, 1, rnd());
    cyc(0, 5'b01000, 1, rnd());
    cyc(0, 5'b00001, 1, rnd());
    cyc(0, 5'b11111, 0, rnd());
    cyc(0, 5'b11111, 0, rnd());
    cyc(1, 5'b11111, 0, rnd());
    cyc(0, '0, 1, '0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, N'($urandom()), $urandom_range(0, 3) != 0, rnd());
    cyc(1, '0, 1, '0);
    for (int i = 0; i < 65540; i++) cyc(0, 5'b11111, 1, rnd());
    chk("saturated", 64'(xfer_count), 64'hFFFF);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, '0);
    chk("drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sub_array_collector.md
SUB_ARRAY_COLLECTOR -- requirements
Module: sub_array_collector

Interface
REQ-001 SHALL have parameter N_SRC, default 5: number of child source ports, legal range 2..8.
REQ-002 SHALL have parameter DATA_W, default 8: payload width per source, legal range 1..64.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, N_SRC: per-source valid, bit i belongs to source i.
REQ-006 SHALL have port in_data, input, N_SRC*DATA_W: per-source payload; source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_ready, output, N_SRC: per-source ready, at most one bit set per cycle.
REQ-008 SHALL have port out_valid, output, 1: output register holds a word.
REQ-009 SHALL have port out_data, output, DATA_W: payload of the held word.
REQ-010 SHALL have port out_src, output, 3: index of the source that supplied the held word.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the held word.
REQ-012 SHALL have port xfer_count, output, 16: count of accepted output words, saturating.

Function
REQ-013 SHALL complete an input transfer on source i in any cycle where in_valid[i] and in_ready[i] are both 1, and an output transfer in any cycle where out_valid and out_ready are both 1.
REQ-014 SHALL define load_en = !rst and (!out_valid or out_ready); in_ready SHALL be all-zero when load_en is 0.
REQ-015 SHALL, when load_en is 1, set in_ready[g] for exactly one requester g: the first index with in_valid set, searching ptr, ptr+1, ..., N_SRC-1, then wrapping to 0.
REQ-016 SHALL keep in_ready all-zero when no in_valid bit is set; in_ready may depend combinationally on in_valid and out_ready.
REQ-017 SHALL, on an input transfer from g, load out_data = source g payload, out_src = g and out_valid = 1 at the next edge (latency 1 cycle), and update ptr = (g+1) mod N_SRC.
REQ-018 SHALL hold ptr unchanged in cycles with no input transfer.
REQ-019 SHALL, on an output transfer with no simultaneous input transfer, clear out_valid at the next edge and keep out_data/out_src unchanged.
REQ-020 SHALL, on simultaneous output and input transfers, replace the held word with the new one and keep out_valid = 1, sustaining 1 word/cycle throughput.
REQ-021 SHALL hold out_data and out_src stable while out_valid = 1 and out_ready = 0; no input transfer occurs in that case.
REQ-022 SHALL increment xfer_count by 1 on each output transfer and saturate at 16'hFFFF (no wrap).
REQ-023 SHALL drop or duplicate no word: every input transfer yields exactly one output transfer, in arbitration order.
REQ-024 SHALL guarantee fairness: a source continuously holding in_valid is granted within N_SRC load-enabled cycles.

Reset
REQ-025 SHALL, at an edge with rst = 1, set out_valid = 0, out_data = 0, out_src = 0, ptr = 0 and xfer_count = 0.
REQ-026 SHALL discard a held word when reset is asserted mid-operation; in_ready SHALL be all-zero in every cycle with rst = 1.
REQ-027 SHALL accept a transfer in the first cycle after rst deasserts if in_valid is set.

Verification
REQ-028 Reset, then in_valid = 5'b00100 with source 2 payload 8'hA5 and out_ready = 1 -> in_ready = 5'b00100; next cycle out_valid = 1, out_data = 8'hA5, out_src = 2, ptr = 3.
REQ-029 All five sources valid for 10 cycles with out_ready = 1 -> out_src sequence 0,1,2,3,4,0,1,2,3,4; out_valid stays high; xfer_count = 10 once all ten words are accepted.
REQ-030 Word held while out_ready = 0 for 4 cycles, sources 1 and 3 valid -> in_ready = 0 and out_data stable for all 4 cycles; the first cycle with out_ready = 1 grants the lowest index at or after ptr.
REQ-031 ptr = 4, only source 0 valid -> in_ready = 5'b00001 (wrap-around); ptr becomes 1.
REQ-032 Force 65535 output transfers, then one more -> xfer_count stays 16'hFFFF.
REQ-033 rst asserted while out_valid = 1 and out_ready = 0 -> out_valid = 0 and xfer_count = 0 next cycle; the held word never appears on the output.
